// File: rtl/booth_wallace_mul.sv
// Radix-4 Booth multiplier with a carry-save reduction of the partial-product rows,
// followed by a final carry-propagate add. Two-stage valid/ready pipeline with flush.
module booth_wallace_mul #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic [TAG_W-1:0]   out_tag
);
  localparam int PW  = 2 * WIDTH;
  localparam int NPP = WIDTH / 2 + 1;
  localparam int EW  = WIDTH + 2;

  // Magnitude selected by a Booth digit, sign-extended to product width; negation
  // is applied by the caller as one's complement plus an injected carry.
  function automatic logic [PW-1:0] booth_mag(input logic signed [EW-1:0] a,
                                              input logic [2:0] d);
    logic signed [PW-1:0] ax;
    ax = PW'(a);
    case (d)
      3'b001, 3'b010, 3'b101, 3'b110: return ax;
      3'b011, 3'b100:                 return ax <<< 1;
      default:                        return '0;
    endcase
  endfunction

  // Full-adder row: {sum, carry shifted one column up}; carry out of the MSB is dropped.
  function automatic logic [2*PW-1:0] csa(input logic [PW-1:0] x,
                                          input logic [PW-1:0] y,
                                          input logic [PW-1:0] z);
    logic [PW-1:0] s;
    logic [PW-1:0] c;
    s = x ^ y ^ z;
    c = (x & y) | (x & z) | (y & z);
    return {s, c[PW-2:0], 1'b0};
  endfunction

  logic               w_adv1;
  logic               w_adv2;
  logic signed [EW-1:0] w_a_ext;
  logic [EW:0]        w_b_pad;
  logic [PW-1:0]      w_sum;
  logic [PW-1:0]      w_cry;

  logic               r_vld_p1;
  logic [PW-1:0]      r_sum_p1;
  logic [PW-1:0]      r_cry_p1;
  logic [TAG_W-1:0]   r_tag_p1;
  logic               r_vld_p2;
  logic [PW-1:0]      r_prod_p2;
  logic [TAG_W-1:0]   r_tag_p2;

  assign w_adv2    = !r_vld_p2 || out_ready;
  assign w_adv1    = !r_vld_p1 || w_adv2;
  assign in_ready  = w_adv1;
  assign out_valid = r_vld_p2;
  assign out_prod  = r_prod_p2;
  assign out_tag   = r_tag_p2;

  // Stage 1: Booth recode and carry-save reduction to sum/carry vectors
  always_comb begin
    logic [PW-1:0]   row;
    logic [PW-1:0]   inj;
    logic [2*PW-1:0] sc;
    logic [2:0]      d;
    logic            neg;
    w_a_ext = in_signed ? {{2{in_a[WIDTH-1]}}, in_a} : {2'b00, in_a};
    w_b_pad = in_signed ? {{2{in_b[WIDTH-1]}}, in_b, 1'b0} : {2'b00, in_b, 1'b0};
    w_sum   = '0;
    w_cry   = '0;
    inj     = '0;
    row     = '0;
    sc      = '0;
    d       = '0;
    neg     = 1'b0;
    for (int i = 0; i < NPP; i++) begin
      d          = w_b_pad[2*i +: 3];
      neg        = d[2] & ~(d[1] & d[0]);
      row        = booth_mag(w_a_ext, d);
      row        = (neg ? ~row : row) << (2 * i);
      inj[2*i]   = neg;
      sc         = csa(w_sum, w_cry, row);
      w_sum      = sc[2*PW-1:PW];
      w_cry      = sc[PW-1:0];
    end
    sc    = csa(w_sum, w_cry, inj);
    w_sum = sc[2*PW-1:PW];
    w_cry = sc[PW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1  <= 1'b0;
      r_sum_p1  <= '0;
      r_cry_p1  <= '0;
      r_tag_p1  <= '0;
      r_vld_p2  <= 1'b0;
      r_prod_p2 <= '0;
      r_tag_p2  <= '0;
    end else begin
      // Stage 2: carry-propagate add of the stage-1 vectors
      if (w_adv2) begin
        r_vld_p2  <= r_vld_p1;
        r_prod_p2 <= r_sum_p1 + r_cry_p1;
        r_tag_p2  <= r_tag_p1;
      end
      if (w_adv1) begin
        r_vld_p1 <= in_valid;
        r_sum_p1 <= w_sum;
        r_cry_p1 <= w_cry;
        r_tag_p1 <= in_tag;
      end
      if (flush) begin
        r_vld_p1 <= 1'b0;
        r_vld_p2 <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_booth_wallace_mul.sv
// Randomised scoreboard bench for booth_wallace_mul: a 32-bit and a 16-bit instance
// run in lockstep against a plain-arithmetic product model.
module tb_booth_wallace_mul;
  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_signed;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_tag;
  logic        out_ready;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_prod;
  logic [4:0]  out_tag;
  logic        in_ready16;
  logic        out_valid16;
  logic [31:0] out_prod16;
  logic [4:0]  out_tag16;

  booth_wallace_mul #(.WIDTH(32), .TAG_W(5)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod), .out_tag(out_tag)
  );

  booth_wallace_mul #(.WIDTH(16), .TAG_W(5)) dut16 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready16),
    .in_signed(in_signed), .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_tag(in_tag),
    .out_valid(out_valid16), .out_ready(out_ready), .out_prod(out_prod16), .out_tag(out_tag16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] p32;
    logic [31:0] p16;
    logic [4:0]  tag;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   strict_lat = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a,
                                          input logic [31:0] b, input int w);
    longint ea;
    longint eb;
    if (w == 32) begin
      ea = s ? longint'($signed(a)) : longint'({32'd0, a});
      eb = s ? longint'($signed(b)) : longint'({32'd0, b});
    end else begin
      ea = s ? longint'($signed(a[15:0])) : longint'({48'd0, a[15:0]});
      eb = s ? longint'($signed(b[15:0])) : longint'({48'd0, b[15:0]});
    end
    return 64'(ea * eb);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 15))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'hFFFF_FFFF;
      5:       return 32'h0000_8000;
      6:       return 32'h0000_7FFF;
      7:       return 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One clock: drive at the falling edge, then score the handshakes that fire next edge.
  task automatic step(input logic v, input logic s, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] t, input logic ordy, input logic fl, input logic rst);
    exp_t        e;
    logic [63:0] r16;
    @(negedge clk);
    in_valid  = v;
    in_signed = s;
    in_a      = a;
    in_b      = b;
    in_tag    = t;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    #1;
    chk("rdy16", 64'(in_ready16), 64'(in_ready));
    chk("vld16", 64'(out_valid16), 64'(out_valid));
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 64'(out_tag), 64'h1_0000_0000);
      end else begin
        e = q.pop_front();
        chk("prod32", out_prod, e.p32);
        chk("prod16", 64'(out_prod16), 64'(e.p16));
        chk("tag", 64'(out_tag), 64'(e.tag));
        chk("tag16", 64'(out_tag16), 64'(e.tag));
        if (strict_lat) chk("latency", 64'(cyc - e.cyc), 64'd2);
      end
    end
    if (rst || fl) begin
      q.delete();
    end else if (in_valid && in_ready) begin
      r16   = ref_mul(s, a, b, 16);
      e.p32 = ref_mul(s, a, b, 32);
      e.p16 = r16[31:0];
      e.tag = t;
      e.cyc = cyc;
      q.push_back(e);
    end
    cyc++;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, ordy, 1'b0, 1'b0);
  endtask

  task automatic directed(input string nm, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] t, input logic [63:0] exp);
    step(1'b1, s, a, b, t, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    chk({nm, "_v1"}, 64'(out_valid), 64'd0);
    idle(1'b1);
    chk({nm, "_v2"}, 64'(out_valid), 64'd1);
    chk({nm, "_prod"}, out_prod, exp);
    chk({nm, "_tag"}, 64'(out_tag), 64'(t));
  endtask

  initial begin
    logic [63:0] held;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
    in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_prod", out_prod, 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd1);

    strict_lat = 1'b1;
    directed("s_m1m1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  64'h0000_0000_0000_0001);
    directed("u_max",  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9,  64'hFFFF_FFFE_0000_0001);
    directed("s_min2", 1'b1, 32'h8000_0000, 32'h8000_0000, 5'd17, 64'h4000_0000_0000_0000);
    directed("s_minx1",1'b1, 32'h8000_0000, 32'h0000_0001, 5'd30, 64'hFFFF_FFFF_8000_0000);

    for (int i = 0; i < 8; i++)
      step(1'b1, 1'($urandom), pick(), pick(), 5'(i), 1'b1, 1'b0, 1'b0);
    repeat (3) idle(1'b1);
    chk("b2b_drained", 64'(q.size()), 64'd0);
    strict_lat = 1'b0;

    held = '0;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'($urandom), pick(), pick(), 5'(k + 8), 1'b0, 1'b0, 1'b0);
      chk("bp_rdy", 64'(in_ready), (k < 2) ? 64'd1 : 64'd0);
      if (k == 2) held = out_prod;
      if (k > 2) chk("bp_hold", out_prod, held);
    end
    for (int k = 0; k < 6; k++)
      step(1'b1, 1'($urandom), pick(), pick(), 5'(k + 16), 1'b1, 1'b0, 1'b0);
    repeat (3) idle(1'b1);
    chk("bp_drained", 64'(q.size()), 64'd0);

    step(1'b1, 1'b1, pick(), pick(), 5'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, pick(), pick(), 5'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, pick(), pick(), 5'd3, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    chk("fl_vld", 64'(out_valid), 64'd0);
    chk("fl_rdy", 64'(in_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      idle(1'b1);
      chk("fl_quiet", 64'(out_valid), 64'd0);
    end

    for (int k = 0; k < 3; k++)
      step(1'b1, 1'($urandom), pick(), pick(), 5'(k + 4), 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, pick(), pick(), 5'd7, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    chk("mrst_vld", 64'(out_valid), 64'd0);
    chk("mrst_prod", out_prod, 64'd0);
    repeat (3) idle(1'b1);

    for (int n = 0; n < 12000; n++)
      step($urandom_range(0, 3) != 0, 1'($urandom), pick(), pick(), 5'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0, 1'b0);
    repeat (4) idle(1'b1);
    chk("rand_drained", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
